vga_multi_buffer: RTL and testbench
===================================

Name: vga_multi_buffer

Overview:
Parametrised N-buffer (2..4) frame store for the VGA path. It is the successor to the fixed double-buffer frame memory.
- CPU side: pixels are written into the current draw buffer; a swap is requested by a store to SWAP_ADDR.
- Scan-out side: reads the display buffer.
- Buffer ownership is tracked per buffer. Display switches only on the frame-start pulse (tear-free).
- Sits between the MEM-stage VGA address decode and the VGA timing generator. Single clock domain; i_frame_start and i_pxlX/Y arrive already synchronised to i_clk.

Parameters:
NUM_BUFS, 3, number of frame buffers; legal 2..4, anything else is an elaboration error
FB_W, 160, frame width in pixels
FB_H, 120, frame height in pixels
COLOR_W, 8, bits per pixel (RGB332 at default)
BASE_ADDR, 32'h1002_0000, byte address of pixel 0; one pixel per 32-bit word
SWAP_ADDR, 32'h1003_0000, swap/control register; status register at SWAP_ADDR+4

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  reset, synchronous, active-low
i_addr  in  32  CPU byte address
i_wdata  in  32  CPU write data; pixel = i_wdata[COLOR_W-1:0]
i_memWrite  in  1  CPU store strobe
i_memRead  in  1  CPU load strobe
o_rdata  out  32  status read data, 1-cycle latency
i_frame_start  in  1  1-cycle pulse at start of vertical blank
i_pxlX  in  $clog2(FB_W)  scan-out column
i_pxlY  in  $clog2(FB_H)  scan-out row
o_color  out  COLOR_W  scan-out pixel, 1-cycle latency
o_wr_stall  out  1  high when no free draw buffer exists
o_disp_idx  out  2  current display buffer index

Behaviour:
- Reset:
  - Per-buffer state: buf0=SHOWING, buf1=DRAWING, others FREE.
  - disp_idx=0, wr_idx=1.
  - o_color=0, o_rdata=0, o_wr_stall=0.
  - Reset mid-frame or mid-swap discards all pending/ready state. Memory contents are not cleared.
- Pixel write:
  - Condition: i_memWrite, BASE_ADDR <= i_addr < BASE_ADDR+4*FB_W*FB_H, and !o_wr_stall.
  - Writes buffer wr_idx at index (i_addr-BASE_ADDR)>>2.
  - Bits [1:0] of i_addr are ignored.
  - Out-of-range addresses are ignored.
  - Writes during stall are dropped.
- Swap request (i_memWrite && i_addr==SWAP_ADDR, data ignored):
  - wr_idx buffer -> READY. Any older READY buffer -> FREE (only newest frame is kept).
  - If a FREE buffer exists, the lowest-index FREE one -> DRAWING and wr_idx updates next cycle.
  - Otherwise o_wr_stall=1 from the next cycle.
  - A request while stalled is ignored.
- i_frame_start:
  - If a READY buffer exists: it -> SHOWING, old SHOWING -> FREE, disp_idx updates.
  - If stalled, the freed buffer -> DRAWING and o_wr_stall drops the next cycle.
  - No READY buffer: no change.
- Simultaneous frame_start and swap request: frame_start is evaluated on pre-request state. The new frame becomes READY and is shown at the following frame_start.
- Scan-out:
  - Pixel index = i_pxlY*FB_W + i_pxlX from buffer disp_idx, registered, 1-cycle latency.
  - i_pxlX >= FB_W or i_pxlY >= FB_H yields o_color=0.
  - disp_idx changes only at i_frame_start.
- Status read (i_memRead at SWAP_ADDR+4), o_rdata next cycle = {24'b0, stall, ready_valid, disp_idx[1:0], 2'b0, wr_idx[1:0]}. Other reads return 0.
- Invariant: exactly one SHOWING buffer; at most one DRAWING and one READY.
  - NUM_BUFS=2 reproduces classic double buffering with stall.
  - NUM_BUFS>=3 never stalls.

Optional Feature:
VGA_STATS_EN:
- Defined: adds 16-bit frames_shown (increments on each display switch) and 16-bit drops (increments per dropped stalled pixel write). Both saturate at 16'hFFFF, cleared by reset, read at SWAP_ADDR+8 as {drops, frames_shown}.
- Undefined: no counters; SWAP_ADDR+8 reads 0.

Decomposition:
- vga_pkg holds:
  - buf_state_t enum {FREE, DRAWING, READY, SHOWING}
  - status bit-position localparams
  - SWAP/status/stats offset constants
- Sub-module vga_frame_ram:
  - simple dual-port RAM, depth NUM_BUFS*FB_W*FB_H, width COLOR_W
  - one write port, one registered read port; infers BRAM
- Top contains the ownership FSM, address decode and muxing.

Test Plan:
1. NUM_BUFS=3: reset -> status read 0x0000_0001 (disp 0, wr 1, not stalled); write 0xA5 at BASE_ADDR+4 -> after swap and frame_start, scan (1,0) gives o_color=0xA5 one cycle later.
2. NUM_BUFS=2: swap request -> o_wr_stall=1 next cycle; pixel write 0x3C dropped; frame_start -> stall=0, wr_idx=0, disp_idx=1.
3. NUM_BUFS=3: two swaps before frame_start -> first READY buffer returns FREE; frame_start shows the second frame; o_wr_stall never asserts.
4. Swap and frame_start in same cycle with no prior READY -> disp_idx unchanged; next frame_start switches display.
5. Scan i_pxlX=FB_W (160) -> o_color=0; write to BASE_ADDR+4*FB_W*FB_H -> memory unchanged.
6. VGA_STATS_EN defined, NUM_BUFS=2: 3 dropped writes and 2 switches -> SWAP_ADDR+8 reads 0x0003_0002; reset mid-stall -> counters 0, stall 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and register map for the multi-buffered VGA frame store.
package vga_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        DRAWING = 2'd1,
        READY   = 2'd2,
        SHOWING = 2'd3
    } buf_state_t;

    // Status word bit positions
    localparam int STAT_WR_IDX_LSB   = 0;
    localparam int STAT_DISP_IDX_LSB = 4;
    localparam int STAT_READY_BIT    = 6;
    localparam int STAT_STALL_BIT    = 7;

    // Offsets relative to SWAP_ADDR
    localparam logic [31:0] SWAP_OFS   = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;
    localparam logic [31:0] STATS_OFS  = 32'h8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vga_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module vga_frame_ram #(
    parameter int DEPTH = 57600,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        rdata_q <= mem[i_raddr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/vga_multi_buffer.sv
// N-buffer (2..4) tear-free VGA frame store with per-buffer ownership tracking.
// Define VGA_STATS_EN to add frames_shown/drops counters readable at SWAP_ADDR+8.
module vga_multi_buffer
    import vga_pkg::*;
#(
    parameter int          NUM_BUFS  = 3,
    parameter int          FB_W      = 160,
    parameter int          FB_H      = 120,
    parameter int          COLOR_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1002_0000,
    parameter logic [31:0] SWAP_ADDR = 32'h1003_0000
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [31:0]             i_addr,
    input  logic [31:0]             i_wdata,
    input  logic                    i_memWrite,
    input  logic                    i_memRead,
    output logic [31:0]             o_rdata,
    input  logic                    i_frame_start,
    input  logic [$clog2(FB_W)-1:0] i_pxlX,
    input  logic [$clog2(FB_H)-1:0] i_pxlY,
    output logic [COLOR_W-1:0]      o_color,
    output logic                    o_wr_stall,
    output logic [1:0]              o_disp_idx
);

    localparam int          PIX      = FB_W * FB_H;
    localparam int          DEPTH    = NUM_BUFS * PIX;
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * PIX);

    generate
        if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_num_bufs
            $error("vga_multi_buffer: NUM_BUFS must be 2..4");
        end
    endgenerate

    // Sized for the maximum; entries at or above NUM_BUFS stay FREE and are never searched.
    buf_state_t  state_q [4];
    buf_state_t  state_d [4];
    logic [1:0]  disp_idx_q, disp_idx_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic        stall_q, stall_d;
    logic [31:0] rdata_q, rdata_d;
    logic        color_valid_q, color_valid_d;

    logic          ready_found;
    logic [1:0]    ready_idx;
    logic          free_found;
    logic [1:0]    free_idx;
    logic          display_switch;
    logic          pix_hit, pix_we, swap_req;
    logic [31:0]   pix_off;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [COLOR_W-1:0] ram_rdata;
    logic          unused_wdata_bits;

    assign pix_hit  = i_memWrite && (i_addr >= BASE_ADDR) && (i_addr < END_ADDR);
    assign pix_we   = pix_hit && !stall_q;
    assign swap_req = i_memWrite && (i_addr == SWAP_ADDR + SWAP_OFS) && !stall_q;
    assign pix_off  = (i_addr - BASE_ADDR) >> 2;
    assign ram_waddr = AW'(32'(wr_idx_q) * 32'(PIX) + pix_off);
    assign ram_raddr = AW'(32'(disp_idx_q) * 32'(PIX) + 32'(i_pxlY) * 32'(FB_W) + 32'(i_pxlX));
    assign color_valid_d = (32'(i_pxlX) < 32'(FB_W)) && (32'(i_pxlY) < 32'(FB_H));
    assign unused_wdata_bits = ^i_wdata[31:COLOR_W];

    vga_frame_ram #(
        .DEPTH (DEPTH),
        .WIDTH (COLOR_W),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (pix_we),
        .i_waddr (ram_waddr),
        .i_wdata (i_wdata[COLOR_W-1:0]),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        ready_found = 1'b0;
        ready_idx   = 2'd0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (state_q[i] == READY) begin
                ready_found = 1'b1;
                ready_idx   = 2'(i);
            end
        end
    end

    // Frame start is resolved first so a same-cycle swap sees the post-switch ownership.
    always_comb begin
        state_d        = state_q;
        disp_idx_d     = disp_idx_q;
        wr_idx_d       = wr_idx_q;
        stall_d        = stall_q;
        display_switch = 1'b0;
        free_found     = 1'b0;
        free_idx       = 2'd0;
        if (i_frame_start && ready_found) begin
            display_switch     = 1'b1;
            state_d[ready_idx] = SHOWING;
            disp_idx_d         = ready_idx;
            if (stall_q) begin
                state_d[disp_idx_q] = DRAWING;
                wr_idx_d            = disp_idx_q;
                stall_d             = 1'b0;
            end else begin
                state_d[disp_idx_q] = FREE;
            end
        end
        if (swap_req) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                if (state_d[i] == READY) begin
                    state_d[i] = FREE;
                end
            end
            state_d[wr_idx_q] = READY;
            for (int i = NUM_BUFS - 1; i >= 0; i--) begin
                if (state_d[i] == FREE) begin
                    free_found = 1'b1;
                    free_idx   = 2'(i);
                end
            end
            if (free_found) begin
                state_d[free_idx] = DRAWING;
                wr_idx_d          = free_idx;
            end else begin
                stall_d = 1'b1;
            end
        end
    end

`ifdef VGA_STATS_EN
    logic [15:0] frames_shown_q, frames_shown_d;
    logic [15:0] drops_q, drops_d;

    assign frames_shown_d = display_switch ? sat_inc16(frames_shown_q) : frames_shown_q;
    assign drops_d        = (pix_hit && stall_q) ? sat_inc16(drops_q) : drops_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            frames_shown_q <= 16'd0;
            drops_q        <= 16'd0;
        end else begin
            frames_shown_q <= frames_shown_d;
            drops_q        <= drops_d;
        end
    end
`endif

    always_comb begin
        rdata_d = 32'd0;
        if (i_memRead) begin
            if (i_addr == SWAP_ADDR + STATUS_OFS) begin
                rdata_d[STAT_STALL_BIT]              = stall_q;
                rdata_d[STAT_READY_BIT]              = ready_found;
                rdata_d[STAT_DISP_IDX_LSB +: 2]      = disp_idx_q;
                rdata_d[STAT_WR_IDX_LSB +: 2]        = wr_idx_q;
            end
`ifdef VGA_STATS_EN
            else if (i_addr == SWAP_ADDR + STATS_OFS) begin
                rdata_d = {drops_q, frames_shown_q};
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= (i == 0) ? SHOWING : ((i == 1) ? DRAWING : FREE);
            end
            disp_idx_q    <= 2'd0;
            wr_idx_q      <= 2'd1;
            stall_q       <= 1'b0;
            rdata_q       <= 32'd0;
            color_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            disp_idx_q    <= disp_idx_d;
            wr_idx_q      <= wr_idx_d;
            stall_q       <= stall_d;
            rdata_q       <= rdata_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign o_color    = color_valid_q ? ram_rdata : '0;
    assign o_rdata    = rdata_q;
    assign o_wr_stall = stall_q;
    assign o_disp_idx = disp_idx_q;

endmodule

// File: tb/tb_vga_multi_buffer.sv
// Directed bench: a 3-buffer and a 2-buffer instance share one stimulus stream.
module tb_vga_multi_buffer;

    localparam logic [31:0] BASE = 32'h1002_0000;
    localparam logic [31:0] SWAP = 32'h1003_0000;
    localparam int          W    = 160;
    localparam int          H    = 120;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic        mem_write, mem_read, frame_start;
    logic [7:0]  pxl_x;
    logic [6:0]  pxl_y;

    logic [31:0] rdata3, rdata2;
    logic [7:0]  color3, color2;
    logic        stall3, stall2;
    logic [1:0]  disp3, disp2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] r3, r2;

    always #5 clk = ~clk;

    vga_multi_buffer #(.NUM_BUFS(3)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_wdata(wdata),
        .i_memWrite(mem_write), .i_memRead(mem_read), .o_rdata(rdata3),
        .i_frame_start(frame_start), .i_pxlX(pxl_x), .i_pxlY(pxl_y),
        .o_color(color3), .o_wr_stall(stall3), .o_disp_idx(disp3)
    );

    vga_multi_buffer #(.NUM_BUFS(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_wdata(wdata),
        .i_memWrite(mem_write), .i_memRead(mem_read), .o_rdata(rdata2),
        .i_frame_start(frame_start), .i_pxlX(pxl_x), .i_pxlY(pxl_y),
        .o_color(color2), .o_wr_stall(stall2), .o_disp_idx(disp2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        $display("[TB] reset");
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        $display("[TB] write addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic pix_write(input int idx, input logic [31:0] d);
        cpu_write(BASE + 32'(4 * idx), d);
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d3, output logic [31:0] d2);
        addr = a; mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        d3 = rdata3;
        d2 = rdata2;
        $display("[TB] read addr=0x%08h dut3=0x%08h dut2=0x%08h", a, d3, d2);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        $display("[TB] frame_start");
    endtask

    task automatic scan(input int x, input int y);
        pxl_x = 8'(x); pxl_y = 7'(y);
        tick();
        $display("[TB] scan (%0d,%0d) dut3=0x%02h dut2=0x%02h", x, y, color3, color2);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0;
        frame_start = 1'b0; pxl_x = '0; pxl_y = '0;

        // 3 buffers: reset state and first frame
        do_reset();
        check_eq("rst_color", 32'(color3), 32'h0);
        check_eq("rst_rdata", rdata3, 32'h0);
        check_eq("rst_stall", 32'(stall3), 32'h0);
        check_eq("rst_disp", 32'(disp3), 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("rst_status", r3, 32'h0000_0001);
        pix_write(0, 32'h10);
        pix_write(1, 32'hA5);
        cpu_write(BASE + 32'(4 * 3 + 3), 32'hFFFF_FF77);
        pix_write(W * H - 1, 32'h99);
        cpu_write(SWAP, 32'hDEAD_BEEF);
        check_eq("swap1_stall3", 32'(stall3), 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("swap1_status", r3, 32'h0000_0042);
        check_eq("swap1_disp", 32'(disp3), 32'h0);
        pulse_frame();
        check_eq("fs1_disp", 32'(disp3), 32'h1);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("fs1_status", r3, 32'h0000_0012);
        cpu_write(BASE - 4, 32'hEE);
        scan(1, 0);
        check_eq("scan_1_0", 32'(color3), 32'hA5);
        scan(3, 0);
        check_eq("scan_addr_lsb", 32'(color3), 32'h77);
        scan(W - 1, H - 1);
        check_eq("scan_last_px", 32'(color3), 32'h99);
        scan(W, 0);
        check_eq("scan_x_oob", 32'(color3), 32'h0);
        scan(0, H);
        check_eq("scan_y_oob", 32'(color3), 32'h0);
        cpu_read(SWAP + 12, r3, r2);
        check_eq("rd_other", r3, 32'h0);
        cpu_read(SWAP, r3, r2);
        check_eq("rd_swap_reg", r3, 32'h0);

        // 3 buffers: two swaps before one frame_start, upper address bound
        pix_write(5, 32'hB1);
        cpu_write(SWAP, 32'h0);
        check_eq("swapA_stall3", 32'(stall3), 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("swapA_status", r3, 32'h0000_0050);
        cpu_write(BASE + 32'(4 * W * H), 32'hEE);
        pix_write(5, 32'hB2);
        cpu_write(SWAP, 32'h0);
        check_eq("swapB_stall3", 32'(stall3), 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("swapB_status", r3, 32'h0000_0052);
        scan(0, 0);
        check_eq("end_addr_ignored", 32'(color3), 32'h10);
        pulse_frame();
        check_eq("fs2_disp", 32'(disp3), 32'h0);
        scan(5, 0);
        check_eq("newest_frame", 32'(color3), 32'hB2);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("fs2_status", r3, 32'h0000_0002);

        // 3 buffers: swap and frame_start in the same cycle, no prior READY
        pix_write(7, 32'hC4);
        addr = SWAP; mem_write = 1'b1; frame_start = 1'b1;
        tick();
        mem_write = 1'b0; frame_start = 1'b0;
        $display("[TB] swap + frame_start");
        check_eq("sim_disp", 32'(disp3), 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("sim_status", r3, 32'h0000_0041);
        pulse_frame();
        check_eq("sim_next_disp", 32'(disp3), 32'h2);
        scan(7, 0);
        check_eq("sim_scan", 32'(color3), 32'hC4);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("sim_next_status", r3, 32'h0000_0021);
        check_eq("never_stalled3", 32'(stall3), 32'h0);

        // 2 buffers: classic double buffering with stall, plus counters
        do_reset();
        check_eq("d2_rst_stall", 32'(stall2), 32'h0);
        pix_write(9, 32'h81);
        cpu_write(SWAP, 32'h0);
        check_eq("d2_stall_on", 32'(stall2), 32'h1);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("d2_stall_status", r2, 32'h0000_00C1);
        pix_write(9, 32'h3C);
        cpu_write(SWAP, 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("d2_swap_ignored", r2, 32'h0000_00C1);
        pulse_frame();
        check_eq("d2_stall_off", 32'(stall2), 32'h0);
        check_eq("d2_disp1", 32'(disp2), 32'h1);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("d2_fs_status", r2, 32'h0000_0010);
        scan(9, 0);
        check_eq("d2_drop_kept", 32'(color2), 32'h81);
        pix_write(9, 32'h42);
        cpu_write(SWAP, 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("d2_stall2_status", r2, 32'h0000_00D0);
        pix_write(9, 32'h99);
        pix_write(10, 32'h98);
        pulse_frame();
        check_eq("d2_disp0", 32'(disp2), 32'h0);
        cpu_read(SWAP + 8, r3, r2);
`ifdef VGA_STATS_EN
        check_eq("d2_stats", r2, 32'h0003_0002);
`else
        check_eq("d2_stats", r2, 32'h0);
`endif
        scan(9, 0);
        check_eq("d2_frame2", 32'(color2), 32'h42);
        cpu_write(SWAP, 32'h0);
        check_eq("d2_restall", 32'(stall2), 32'h1);
        do_reset();
        check_eq("d2_rst_mid_stall", 32'(stall2), 32'h0);
        cpu_read(SWAP + 8, r3, r2);
        check_eq("d2_stats_cleared", r2, 32'h0);
        cpu_read(SWAP + 4, r3, r2);
        check_eq("d2_rst_status", r2, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
